uart_tx_ctrl: RTL and testbench

Synthesizable 8-bit UART transmitter with a small input FIFO, driving the `uart_tx` pad of the SoC peripheral subsystem. It is the transmitting end of the 8N1 / 8E1 link decoded by `uart_tb_rx` in the system bench. Software-side logic pushes bytes through a valid/ready port. The block serialises them LSB-first with a programmable bit period, optional parity and one or two stop bits.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx_ctrl.sv | 124 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit path
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO with occupancy counter
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is dropped even when a pop happens in the same cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - 8-bit UART transmitter with input FIFO, parity and 1/2 stop bits
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DIV_W-1:0]           div_i,
    input  logic                       parity_en_i,
    input  logic                       parity_odd_i,
    input  logic                       stop2_i,
    input  logic [UART_DATA_W-1:0]     tx_data_i,
    input  logic                       tx_valid_i,
    output logic                       tx_ready_o,
    output logic                       tx_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

    uart_tx_state_t         state;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic [UART_DATA_W-1:0] head;
    logic [DIV_W-1:0]       baud_cnt;
    logic [DIV_W-1:0]       div_lat;
    logic                   par_en_lat;
    logic                   par_bit_lat;
    logic                   stop2_lat;
    logic [2:0]             bit_cnt;
    logic                   stop_cnt;
    logic [UART_DATA_W-1:0] shift_q;
    logic                   bit_end;
    logic                   last_stop;

    uart_tx_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_valid_i),
        .push_data (tx_data_i),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_o)
    );

    assign tx_ready_o = !fifo_full;
    assign busy_o     = (state != IDLE) || !fifo_empty;
    assign bit_end    = (baud_cnt == '0);
    assign last_stop  = (state == STOP) && bit_end && (!stop2_lat || stop_cnt);
    // Popping on the last stop cycle chains frames with no idle gap.
    assign pop        = !fifo_empty && ((state == IDLE) || last_stop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_o        <= 1'b1;
            baud_cnt    <= '0;
            div_lat     <= '0;
            par_en_lat  <= 1'b0;
            par_bit_lat <= 1'b0;
            stop2_lat   <= 1'b0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            shift_q     <= '0;
        end else if (pop) begin
            // Frame settings are captured here so mid-frame input changes wait for the next frame.
            state       <= START;
            tx_o        <= 1'b0;
            shift_q     <= head;
            div_lat     <= div_i;
            baud_cnt    <= div_i;
            par_en_lat  <= parity_en_i;
            par_bit_lat <= uart_parity(head, parity_odd_i);
            stop2_lat   <= stop2_i;
        end else if (state != IDLE && !bit_end) begin
            baud_cnt <= baud_cnt - DIV_W'(1);
        end else begin
            baud_cnt <= div_lat;
            case (state)
                START: begin
                    state   <= DATA;
                    tx_o    <= shift_q[0];
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) begin
                        state    <= par_en_lat ? PARITY : STOP;
                        tx_o     <= par_en_lat ? par_bit_lat : 1'b1;
                        stop_cnt <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shift_q <= shift_q >> 1;
                        tx_o    <= shift_q[1];
                    end
                end
                PARITY: begin
                    state    <= STOP;
                    tx_o     <= 1'b1;
                    stop_cnt <= 1'b0;
                end
                STOP: begin
                    if (last_stop) begin
                        state <= IDLE;
                    end else begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_o     <= 1'b1;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] div;
    logic        par_en;
    logic        par_odd;
    logic        stop2;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx;
    logic        busy;
    logic [3:0]  count;

    int passed = 0;
    int total  = 0;

    uart_tx_ctrl #(.DEPTH(8), .DIV_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_i        (div),
        .parity_en_i  (par_en),
        .parity_odd_i (par_odd),
        .stop2_i      (stop2),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .tx_o         (tx),
        .busy_o       (busy),
        .fifo_count_o (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Waits for the start bit, then requires every cycle of every bit to hold the expected level.
    task automatic check_frame(input string tag, input logic [7:0] b, input int d,
                               input bit pe, input bit pbit, input bit s2, output int waited);
        logic [11:0] pat;
        int          n;
        int          bad;
        pat    = '0;
        waited = 0;
        for (int i = 0; i < 8; i++) pat[i+1] = b[i];
        n = 9;
        if (pe) begin
            pat[n] = pbit;
            n++;
        end
        pat[n] = 1'b1;
        n++;
        if (s2) begin
            pat[n] = 1'b1;
            n++;
        end
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < 3000);
        if (tx !== 1'b0) begin
            check({tag, " start timeout"}, 32'(tx), 0);
            return;
        end
        for (int bi = 0; bi < n; bi++) begin
            bad = 0;
            for (int c = 0; c <= d; c++) begin
                if (!(bi == 0 && c == 0)) @(negedge clk);
                if (tx !== pat[bi]) bad++;
            end
            check($sformatf("%s bit%0d bad_cycles", tag, bi), bad, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int bad;
        div      = 16'd31;
        par_en   = 1'b0;
        par_odd  = 1'b0;
        stop2    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 1);
        check("reset ready", 32'(tx_ready), 1);
        check("reset busy", 32'(busy), 0);
        check("reset count", 32'(count), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle tx", 32'(tx), 1);
        check("idle busy", 32'(busy), 0);

        // Single byte, div 31, 8N1
        push(8'h55);
        check("t1 count", 32'(count), 1);
        check("t1 busy", 32'(busy), 1);
        check("t1 tx before start", 32'(tx), 1);
        check_frame("t1", 8'h55, 31, 1'b0, 1'b0, 1'b0, w);
        check("t1 latency", w, 1);
        @(negedge clk);
        check("t1 busy after", 32'(busy), 0);
        check("t1 tx after", 32'(tx), 1);

        // Even parity, two stop bits
        div = 16'd3; par_en = 1'b1; par_odd = 1'b0; stop2 = 1'b1;
        push(8'h07);
        check_frame("t2", 8'h07, 3, 1'b1, 1'b1, 1'b1, w);
        check("t2 latency", w, 1);
        @(negedge clk);
        check("t2 busy after", 32'(busy), 0);

        // Odd and even parity corner bytes
        div = 16'd1; par_odd = 1'b1; stop2 = 1'b0;
        push(8'h00);
        check_frame("t3 00 odd", 8'h00, 1, 1'b1, 1'b1, 1'b0, w);
        @(negedge clk);
        push(8'hFF);
        check_frame("t3 ff odd", 8'hFF, 1, 1'b1, 1'b1, 1'b0, w);
        @(negedge clk);
        par_odd = 1'b0;
        push(8'hFF);
        check_frame("t3 ff even", 8'hFF, 1, 1'b1, 1'b0, 1'b0, w);
        @(negedge clk);
        check("t3 busy after", 32'(busy), 0);

        // Burst of 9 bytes into an 8-deep FIFO, gapless frames
        div = 16'd3; par_en = 1'b0; stop2 = 1'b0;
        fork
            begin
                for (int i = 1; i <= 9; i++) begin
                    tx_data  = 8'(i);
                    tx_valid = 1'b1;
                    @(negedge clk);
                end
                check("t4 full count", 32'(count), 8);
                check("t4 full ready", 32'(tx_ready), 0);
                tx_data = 8'h0A;
                repeat (3) @(negedge clk);
                tx_valid = 1'b0;
                check("t4 push while full ignored", 32'(count), 8);
            end
            begin
                for (int k = 0; k < 9; k++) begin
                    check_frame($sformatf("t4 byte%0d", k + 1), 8'(k + 1), 3, 1'b0, 1'b0, 1'b0, w);
                    if (k > 0) check($sformatf("t4 gapless%0d", k + 1), w, 1);
                end
            end
        join
        @(negedge clk);
        check("t4 busy after", 32'(busy), 0);
        check("t4 count after", 32'(count), 0);

        // Divisor and mode change mid-frame only apply to the next frame
        div = 16'd31;
        fork
            check_frame("t5 first", 8'hA3, 31, 1'b0, 1'b0, 1'b0, w);
            begin
                push(8'hA3);
                repeat (100) @(negedge clk);
                div = 16'd7; par_en = 1'b1; stop2 = 1'b1;
            end
        join
        @(negedge clk);
        push(8'h3C);
        check_frame("t5 second", 8'h3C, 7, 1'b1, 1'b0, 1'b1, w);
        @(negedge clk);
        check("t5 busy after", 32'(busy), 0);

        // Reset during DATA with three bytes queued
        div = 16'd7; par_en = 1'b0; stop2 = 1'b0;
        push(8'h00);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (10) @(negedge clk);
        check("t6 tx in data", 32'(tx), 0);
        check("t6 count queued", 32'(count), 3);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async tx", 32'(tx), 1);
        check("t6 async count", 32'(count), 0);
        check("t6 async busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check("t6 idle after reset", bad, 0);
        check("t6 busy idle", 32'(busy), 0);
        push(8'h5A);
        check_frame("t6 new frame", 8'h5A, 7, 1'b0, 1'b0, 1'b0, w);
        check("t6 latency", w, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
